// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the CPU, DMA and memory-side signals of the shared LC-3 memory port.
//
// Signals
//   CPU_CS/CPU_WE/CPU_ADDR/CPU_WDATA      CPU level request, held until CPU_READY
//   CPU_RDATA/CPU_READY                   read data and one-cycle completion pulse to the CPU
//   DMA_REQ/DMA_WE/DMA_ADDR/DMA_WDATA     DMA level request, held until DMA_READY
//   DMA_RDATA/DMA_READY                   read data and one-cycle completion pulse to DMA
//   MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA      memory command, one MEM_EN cycle per access
//   MEM_RDATA                             memory read data, valid MEM_LATENCY cycles after MEM_EN
//   BUSY/OWNER                            arbiter status (OWNER: 0 = CPU, 1 = DMA)
//
// Modports
//   slave   the arbiter's view
//   master  the view of the environment that drives requests and models memory
interface mem_arbiter_if;
    logic        CPU_CS;
    logic        CPU_WE;
    logic [15:0] CPU_ADDR;
    logic [15:0] CPU_WDATA;
    logic [15:0] CPU_RDATA;
    logic        CPU_READY;

    logic        DMA_REQ;
    logic        DMA_WE;
    logic [15:0] DMA_ADDR;
    logic [15:0] DMA_WDATA;
    logic [15:0] DMA_RDATA;
    logic        DMA_READY;

    logic        MEM_EN;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;

    logic        BUSY;
    logic        OWNER;

    modport slave (
        input  CPU_CS, CPU_WE, CPU_ADDR, CPU_WDATA,
        output CPU_RDATA, CPU_READY,
        input  DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA,
        output DMA_RDATA, DMA_READY,
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_RDATA,
        output BUSY, OWNER
    );

    modport master (
        output CPU_CS, CPU_WE, CPU_ADDR, CPU_WDATA,
        input  CPU_RDATA, CPU_READY,
        output DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA,
        input  DMA_RDATA, DMA_READY,
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_RDATA,
        input  BUSY, OWNER
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single LC-3 memory port between the CPU control FSM and a DMA/IO
// requester. Every access runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE: the winner's command is
// latched at grant, MEM_EN is driven for one cycle, the fixed memory latency is waited out and
// the owner gets a one-cycle READY with the read data passed straight through from memory.
// The CPU has priority; a starvation counter hands DMA the next arbitration after
// STARVE_LIMIT consecutive CPU grants made while DMA was waiting.
//
// Ports
//   CLK    clock, rising edge
//   RESET  synchronous, active-low reset
//   bus    mem_arbiter_if.slave: CPU and DMA request/response, memory command/data, BUSY, OWNER
//
// Parameters
//   MEM_LATENCY   cycles from the MEM_EN cycle to the cycle in which MEM_RDATA is valid (>= 1)
//   STARVE_LIMIT  consecutive CPU grants tolerated while DMA waits (>= 1)
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic          CLK,
    input logic          RESET,
    mem_arbiter_if.slave bus
);

    // wait_cnt only has to reach MEM_LATENCY-2, the index of the last WAIT cycle.
    localparam int unsigned WaitW   = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    localparam logic [WaitW-1:0]   WaitLast  = WaitW'((MEM_LATENCY >= 2) ? MEM_LATENCY - 2 : 0);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic               mem_we_q, mem_we_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;
    logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [15:0]        cpu_rdata_q, cpu_rdata_d;
    logic [15:0]        dma_rdata_q, dma_rdata_d;

    logic any_req;
    logic grant_dma;
    logic cpu_ready;
    logic dma_ready;

    assign any_req = bus.CPU_CS | bus.DMA_REQ;

    // DMA wins when it is alone, or when the CPU has used up its run of grants.
    assign grant_dma = bus.DMA_REQ & (~bus.CPU_CS | (starve_cnt_q == StarveMax));

    assign cpu_ready = (state_q == StResp) & ~owner_q;
    assign dma_ready = (state_q == StResp) &  owner_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StIssue;
                    owner_d = grant_dma;
                    if (grant_dma) begin
                        mem_we_d     = bus.DMA_WE;
                        mem_addr_d   = bus.DMA_ADDR;
                        mem_wdata_d  = bus.DMA_WDATA;
                        starve_cnt_d = '0;
                    end else begin
                        mem_we_d    = bus.CPU_WE;
                        mem_addr_d  = bus.CPU_ADDR;
                        mem_wdata_d = bus.CPU_WDATA;
                        // Only CPU grants that actually made DMA wait count towards starvation.
                        if (bus.DMA_REQ && (starve_cnt_q != StarveMax)) begin
                            starve_cnt_d = starve_cnt_q + StarveW'(1);
                        end
                    end
                end
            end

            StIssue: begin
                wait_cnt_d = '0;
                state_d    = (MEM_LATENCY == 1) ? StResp : StWait;
            end

            StWait: begin
                if (wait_cnt_q == WaitLast) begin
                    wait_cnt_d = '0;
                    state_d    = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end

            StResp: begin
                // Always pass through IDLE so the CPU FSM has a cycle to drop CS.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read data is captured on the way out of RESP and held for the requester afterwards.
    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        if (cpu_ready) begin
            cpu_rdata_d = bus.MEM_RDATA;
        end
        if (dma_ready) begin
            dma_rdata_d = bus.MEM_RDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.MEM_EN    = (state_q == StIssue);
    // The latched WE is only exposed while MEM_EN is high.
    assign bus.MEM_WE    = (state_q == StIssue) & mem_we_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_WDATA = mem_wdata_q;

    assign bus.CPU_READY = cpu_ready;
    assign bus.DMA_READY = dma_ready;
    assign bus.CPU_RDATA = cpu_ready ? bus.MEM_RDATA : cpu_rdata_q;
    assign bus.DMA_RDATA = dma_ready ? bus.MEM_RDATA : dma_rdata_q;

    assign bus.BUSY  = (state_q != StIdle);
    assign bus.OWNER = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    mem_arbiter_if if2 ();
    mem_arbiter_if if1 ();
    mem_arbiter_if if4 ();

    mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(3)) dut2 (.CLK(CLK), .RESET(RESET), .bus(if2.slave));
    mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(3)) dut1 (.CLK(CLK), .RESET(RESET), .bus(if1.slave));
    mem_arbiter #(.MEM_LATENCY(4), .STARVE_LIMIT(3)) dut4 (.CLK(CLK), .RESET(RESET), .bus(if4.slave));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory model for the latency-2 instance: data appears only in the valid cycle.
    function automatic logic [15:0] mem_model(input logic [15:0] a);
        case (a)
            16'h3000: mem_model = 16'h1234;
            16'h3001: mem_model = 16'h5678;
            16'h4000: mem_model = 16'hBEEF;
            default:  mem_model = a ^ 16'hA5A5;
        endcase
    endfunction

    int          rd_due = -100;
    logic [15:0] rd_addr = 16'h0000;
    always @(posedge CLK) begin
        if (if2.MEM_EN) begin
            rd_addr <= if2.MEM_ADDR;
            rd_due  <= cyc + 2;
        end
    end
    assign if2.MEM_RDATA = (cyc == rd_due) ? mem_model(rd_addr) : 16'hDEAD;
    assign if1.MEM_RDATA = 16'h0F0F;
    assign if4.MEM_RDATA = 16'hF0F0;

    // Scoreboard
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          cyc;
    } req_t;

    typedef struct {
        logic        owner;
        logic        chk_data;
        logic [15:0] rdata;
        int          cyc;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    task automatic push_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input int c);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.cyc = c;
        req_q.push_back(r);
    endtask

    task automatic push_resp(input logic owner, input logic chk, input logic [15:0] rdata,
                             input int c);
        resp_t r;
        r.owner = owner; r.chk_data = chk; r.rdata = rdata; r.cyc = c;
        resp_q.push_back(r);
    endtask

    // Monitor: compares every memory command and every READY against the queues.
    always @(negedge CLK) begin
        if (if2.MEM_EN) begin
            if (req_q.size() == 0) begin
                check("unexpected_mem_en", 32'(req_q.size()), 32'd1);
            end else begin
                req_t e;
                e = req_q.pop_front();
                check("mem_en_cycle", 32'(cyc), 32'(e.cyc));
                check("mem_we", 32'(if2.MEM_WE), 32'(e.we));
                check("mem_addr", 32'(if2.MEM_ADDR), 32'(e.addr));
                if (e.we) check("mem_wdata", 32'(if2.MEM_WDATA), 32'(e.wdata));
                check("busy_issue", 32'(if2.BUSY), 32'd1);
            end
        end
        if (if2.CPU_READY || if2.DMA_READY) begin
            check("ready_onehot", 32'(if2.CPU_READY) + 32'(if2.DMA_READY), 32'd1);
            if (resp_q.size() == 0) begin
                check("unexpected_ready", 32'(resp_q.size()), 32'd1);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                check("ready_side_dma", 32'(if2.DMA_READY), 32'(e.owner));
                check("owner", 32'(if2.OWNER), 32'(e.owner));
                check("busy_resp", 32'(if2.BUSY), 32'd1);
                if (e.chk_data) begin
                    if (e.owner) check("dma_rdata", 32'(if2.DMA_RDATA), 32'(e.rdata));
                    else         check("cpu_rdata", 32'(if2.CPU_RDATA), 32'(e.rdata));
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One complete access on the latency-2 instance, starting in an IDLE cycle.
    task automatic access(input logic dma, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp);
        int t;
        t = cyc;
        if (dma) begin
            if2.DMA_REQ = 1'b1; if2.DMA_WE = we; if2.DMA_ADDR = addr; if2.DMA_WDATA = wdata;
        end else begin
            if2.CPU_CS = 1'b1; if2.CPU_WE = we; if2.CPU_ADDR = addr; if2.CPU_WDATA = wdata;
        end
        push_req(we, addr, wdata, t + 1);
        push_resp(dma, !we, exp, t + 3);
        wait_cyc(t + 4);
        if (dma) if2.DMA_REQ = 1'b0;
        else     if2.CPU_CS  = 1'b0;
        if (!we) begin
            if (dma) check("dma_rdata_hold", 32'(if2.DMA_RDATA), 32'(exp));
            else     check("cpu_rdata_hold", 32'(if2.CPU_RDATA), 32'(exp));
        end
    endtask

    task automatic idle_inputs();
        if2.CPU_CS = 0; if2.CPU_WE = 0; if2.CPU_ADDR = 0; if2.CPU_WDATA = 0;
        if2.DMA_REQ = 0; if2.DMA_WE = 0; if2.DMA_ADDR = 0; if2.DMA_WDATA = 0;
        if1.CPU_CS = 0; if1.CPU_WE = 0; if1.CPU_ADDR = 0; if1.CPU_WDATA = 0;
        if1.DMA_REQ = 0; if1.DMA_WE = 0; if1.DMA_ADDR = 0; if1.DMA_WDATA = 0;
        if4.CPU_CS = 0; if4.CPU_WE = 0; if4.CPU_ADDR = 0; if4.CPU_WDATA = 0;
        if4.DMA_REQ = 0; if4.DMA_WE = 0; if4.DMA_ADDR = 0; if4.DMA_WDATA = 0;
    endtask

    int t;
    int en1, en4, rdy1_n, rdy4_n, en1_cyc, en4_cyc, rdy1, rdy4;
    logic [15:0] rd1, rd4;

    initial begin
        idle_inputs();
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset state
        @(negedge CLK);
        check("rst_mem_en", 32'(if2.MEM_EN), 32'd0);
        check("rst_mem_we", 32'(if2.MEM_WE), 32'd0);
        check("rst_mem_addr", 32'(if2.MEM_ADDR), 32'd0);
        check("rst_mem_wdata", 32'(if2.MEM_WDATA), 32'd0);
        check("rst_cpu_ready", 32'(if2.CPU_READY), 32'd0);
        check("rst_dma_ready", 32'(if2.DMA_READY), 32'd0);
        check("rst_cpu_rdata", 32'(if2.CPU_RDATA), 32'd0);
        check("rst_dma_rdata", 32'(if2.DMA_RDATA), 32'd0);
        check("rst_busy", 32'(if2.BUSY), 32'd0);
        check("rst_owner", 32'(if2.OWNER), 32'd0);
        check("rst_starve", 32'(dut2.starve_cnt_q), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // CPU read, then DMA write
        access(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234);
        access(1'b1, 1'b1, 16'hFE00, 16'h00AA, 16'h0000);

        // Both held: CPU, CPU, CPU, DMA, CPU
        t = cyc;
        if2.CPU_CS = 1; if2.CPU_WE = 0; if2.CPU_ADDR = 16'h3000;
        if2.DMA_REQ = 1; if2.DMA_WE = 0; if2.DMA_ADDR = 16'h3001;
        for (int k = 0; k < 5; k++) begin
            logic o;
            o = (k == 3);
            push_req(1'b0, o ? 16'h3001 : 16'h3000, 16'h0000, t + 4 * k + 1);
            push_resp(o, 1'b1, o ? 16'h5678 : 16'h1234, t + 4 * k + 3);
        end
        wait_cyc(t + 9);
        @(negedge CLK);
        check("starve_sat", 32'(dut2.starve_cnt_q), 32'd3);
        wait_cyc(t + 13);
        @(negedge CLK);
        check("starve_clear", 32'(dut2.starve_cnt_q), 32'd0);
        wait_cyc(t + 20);
        if2.CPU_CS = 0;
        if2.DMA_REQ = 0;

        // Address change during WAIT does not disturb the latched command
        t = cyc;
        if2.CPU_CS = 1; if2.CPU_WE = 0; if2.CPU_ADDR = 16'h3000;
        push_req(1'b0, 16'h3000, 16'h0000, t + 1);
        push_resp(1'b0, 1'b1, 16'h1234, t + 3);
        wait_cyc(t + 2);
        if2.CPU_ADDR = 16'h4000;
        @(negedge CLK);
        check("addr_hold_wait", 32'(if2.MEM_ADDR), 32'h3000);
        wait_cyc(t + 3);
        @(negedge CLK);
        check("addr_hold_resp", 32'(if2.MEM_ADDR), 32'h3000);
        wait_cyc(t + 4);
        if2.CPU_CS = 0;

        // Reset during WAIT aborts the access; the held request is then regranted
        t = cyc;
        if2.CPU_CS = 1; if2.CPU_WE = 0; if2.CPU_ADDR = 16'h3001;
        push_req(1'b0, 16'h3001, 16'h0000, t + 1);
        wait_cyc(t + 2);
        RESET = 1'b0;
        wait_cyc(t + 3);
        RESET = 1'b1;
        @(negedge CLK);
        check("abort_mem_en", 32'(if2.MEM_EN), 32'd0);
        check("abort_busy", 32'(if2.BUSY), 32'd0);
        check("abort_cpu_ready", 32'(if2.CPU_READY), 32'd0);
        check("abort_mem_addr", 32'(if2.MEM_ADDR), 32'd0);
        check("abort_cpu_rdata", 32'(if2.CPU_RDATA), 32'd0);
        check("abort_dma_rdata", 32'(if2.DMA_RDATA), 32'd0);
        check("abort_owner", 32'(if2.OWNER), 32'd0);
        push_req(1'b0, 16'h3001, 16'h0000, t + 4);
        push_resp(1'b0, 1'b1, 16'h5678, t + 6);
        wait_cyc(t + 7);
        if2.CPU_CS = 0;

        // Latency 1 and latency 4 instances, same request
        t = cyc;
        en1 = 0; en4 = 0; rdy1_n = 0; rdy4_n = 0;
        en1_cyc = -1; en4_cyc = -1; rdy1 = -1; rdy4 = -1; rd1 = 0; rd4 = 0;
        if1.CPU_CS = 1; if1.CPU_ADDR = 16'h3000;
        if4.CPU_CS = 1; if4.CPU_ADDR = 16'h3000;
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            if (if1.MEM_EN) begin en1++; en1_cyc = cyc; end
            if (if4.MEM_EN) begin en4++; en4_cyc = cyc; end
            if (if1.CPU_READY) begin rdy1_n++; rdy1 = cyc; rd1 = if1.CPU_RDATA; end
            if (if4.CPU_READY) begin rdy4_n++; rdy4 = cyc; rd4 = if4.CPU_RDATA; end
            @(posedge CLK);
            #1;
            if (cyc == t + 3) if1.CPU_CS = 0;
            if (cyc == t + 6) if4.CPU_CS = 0;
        end
        check("lat1_en_count", 32'(en1), 32'd1);
        check("lat1_en_cycle", 32'(en1_cyc), 32'(t + 1));
        check("lat1_ready_count", 32'(rdy1_n), 32'd1);
        check("lat1_ready_cycle", 32'(rdy1), 32'(t + 2));
        check("lat1_rdata", 32'(rd1), 32'h0F0F);
        check("lat4_en_count", 32'(en4), 32'd1);
        check("lat4_en_cycle", 32'(en4_cyc), 32'(t + 1));
        check("lat4_ready_count", 32'(rdy4_n), 32'd1);
        check("lat4_ready_cycle", 32'(rdy4), 32'(t + 5));
        check("lat4_rdata", 32'(rd4), 32'hF0F0);

        repeat (3) @(posedge CLK);
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single LC-3 memory port between the CPU control FSM and a DMA/IO requester.
- Each requester uses a level request with a one-cycle READY completion pulse, matching the FSM's hold-CS-until-READY states (MEM11, MEM22, LDI2, STI2, TRAP2, FETCH2).
- Sequences every access as grant, memory enable, fixed-latency wait, then response.
- The CPU has priority; a starvation counter guarantees DMA progress.

Parameters:
- MEM_LATENCY, 2: cycles from the MEM_EN cycle to the cycle in which MEM_RDATA is valid. Legal range ≥1.
- STARVE_LIMIT, 3: number of consecutive CPU grants made while DMA is waiting, after which DMA wins the next arbitration. Legal range ≥1.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-low reset (0 = reset).
- CPU_CS  in  1  CPU request; held until CPU_READY.
- CPU_WE  in  1  CPU write (1) or read (0).
- CPU_ADDR  in  16  CPU address (MAR).
- CPU_WDATA  in  16  CPU write data (MDR).
- CPU_RDATA  out  16  read data to the CPU.
- CPU_READY  out  1  one-cycle CPU completion pulse.
- DMA_REQ  in  1  DMA request; held until DMA_READY.
- DMA_WE  in  1  DMA write (1) or read (0).
- DMA_ADDR  in  16  DMA address.
- DMA_WDATA  in  16  DMA write data.
- DMA_RDATA  out  16  read data to DMA.
- DMA_READY  out  1  one-cycle DMA completion pulse.
- MEM_EN  out  1  memory enable; one cycle per access.
- MEM_WE  out  1  memory write strobe; valid only with MEM_EN.
- MEM_ADDR  out  16  latched access address.
- MEM_WDATA  out  16  latched write data.
- MEM_RDATA  in  16  memory read data; valid MEM_LATENCY cycles after the MEM_EN cycle.
- BUSY  out  1  high in every state except IDLE.
- OWNER  out  1  current or last owner: 0 = CPU, 1 = DMA.

Behaviour:
- Reset (RESET=0 at a rising edge) → state IDLE. All of the following are 0: MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, CPU_READY, DMA_READY, CPU_RDATA, DMA_RDATA, BUSY, OWNER, starve_cnt, wait_cnt.
- Reset mid-access aborts it: no READY pulse; MEM_EN is 0 in the next cycle.
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE, when a request is sampled at the edge:
  - Only CPU_CS: grant CPU.
  - Only DMA_REQ: grant DMA.
  - Both: grant CPU unless starve_cnt == STARVE_LIMIT, in which case grant DMA.
- On a grant, register OWNER and latch the winner's WE, ADDR and WDATA into MEM_WE, MEM_ADDR and MEM_WDATA, then go to ISSUE.
- Latched values are immune to later requester changes until the next grant.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on a CPU grant while DMA_REQ=1.
  - Clears on any DMA grant.
  - Otherwise holds.
- ISSUE: MEM_EN=1 for exactly one cycle; MEM_WE=latched WE in this cycle and 0 in every other cycle. Go to WAIT, or directly to RESP if MEM_LATENCY==1.
- WAIT: occupies MEM_LATENCY-1 cycles, counted by wait_cnt; MEM_EN=0. Then RESP.
- RESP: one cycle.
  - The owner's READY=1.
  - The owner's RDATA = MEM_RDATA (combinational pass-through) during RESP and is registered at the end of RESP; it holds afterwards.
  - The non-owner's READY and RDATA are unaffected.
  - For writes, READY pulses the same way; RDATA still updates to MEM_RDATA (don't-care to requesters).
  - Always returns to IDLE.
- Latency: a request sampled at the end of cycle t gives ISSUE in t+1 and READY in cycle t+1+MEM_LATENCY (t+3 at default).
- Minimum gap between READY and the next MEM_EN is 2 cycles (one IDLE cycle, then ISSUE).
- Turnaround: the mandatory IDLE cycle lets the CPU FSM drop CS after READY. A request still high in IDLE is treated as a new access.
- Withdrawal: if the owner drops its request during ISSUE or WAIT, the access still completes and READY still pulses.
- A new request from either side during ISSUE, WAIT or RESP is held off and arbitrated in the next IDLE.
- Never more than one READY high per cycle.
- BUSY=1 in ISSUE, WAIT and RESP.

Test Plan:
- Reset release, CPU_CS=1, WE=0, ADDR=0x3000; MEM_RDATA=0x1234 in the valid cycle → MEM_EN=1 at t+1 with MEM_ADDR=0x3000 and MEM_WE=0; CPU_READY=1 at t+3 with CPU_RDATA=0x1234; DMA_READY stays 0.
- DMA write, ADDR=0xFE00, WDATA=0x00AA → one MEM_EN cycle with MEM_WE=1, MEM_ADDR=0xFE00, MEM_WDATA=0x00AA; DMA_READY at t+3; OWNER=1.
- CPU_CS and DMA_REQ held continuously with STARVE_LIMIT=3 → grant order CPU, CPU, CPU, DMA, CPU…; DMA_READY after exactly 3 CPU_READY pulses; starve_cnt returns to 0.
- MEM_LATENCY=1 → READY at t+2 with no WAIT cycle. MEM_LATENCY=4 → READY at t+5 and exactly one MEM_EN pulse.
- Change CPU_ADDR 0x3000→0x4000 during WAIT → MEM_ADDR stays 0x3000; the access completes normally.
- Assert RESET=0 during WAIT → next cycle state IDLE, all outputs 0, no READY pulse. After release, a held CPU_CS is regranted with a fresh MEM_EN.
